// File: rtl/inta_sequencer_if.sv
// Bundle of the signals between the 8259 control logic and the
// interrupt-acknowledge sequencer. The sequencer uses the slave modport;
// whatever block drives INTA, the ICW fields and the winning request
// uses the master modport.
interface inta_sequencer_if;
    // Configuration and handshake into the sequencer
    logic       icw1_write;
    logic       int_ack;
    logic [7:0] interrupt_vector;
    logic [4:0] icw2_base;
    logic [7:0] icw3_slave_mask;
    logic [2:0] cascade_id;
    logic       sp_en;
    logic       single_mode;
    logic       auto_eoi;
    logic [2:0] cascade_i;

    // Results produced by the sequencer
    logic       interrupt_to_cpu;
    logic       freeze;
    logic [7:0] set_isr;
    logic [7:0] clear_IRR;
    logic [7:0] aeoi_clear;
    logic [2:0] cascade_o;
    logic       cascade_oe;
    logic       out_control_logic_data;
    logic [7:0] control_logic_data;

    // Side that owns INTA, the ICW fields and the request vector
    modport master (
        output icw1_write, int_ack, interrupt_vector, icw2_base,
               icw3_slave_mask, cascade_id, sp_en, single_mode,
               auto_eoi, cascade_i,
        input  interrupt_to_cpu, freeze, set_isr, clear_IRR, aeoi_clear,
               cascade_o, cascade_oe, out_control_logic_data,
               control_logic_data
    );

    // The acknowledge sequencer itself
    modport slave (
        input  icw1_write, int_ack, interrupt_vector, icw2_base,
               icw3_slave_mask, cascade_id, sp_en, single_mode,
               auto_eoi, cascade_i,
        output interrupt_to_cpu, freeze, set_isr, clear_IRR, aeoi_clear,
               cascade_o, cascade_oe, out_control_logic_data,
               control_logic_data
    );
endinterface

// File: rtl/inta_sequencer.sv
// 8259 interrupt-acknowledge sequencer, 8086 mode (two INTA pulses).
// Raises INT while a request is pending, then walks through the two INTA
// pulses: first pulse latches the winning level, strobes ISR set / IRR clear
// and freezes IRR; second pulse puts {ICW2 base, level} on the data bus
// (unless a cascaded slave owns the vector). Automatic EOI clears the ISR
// bit when the second pulse ends. Every output comes straight from a flop.
module inta_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic              clk,
    input  logic              rst_n,
    inta_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        GAP  = 2'd2,
        ACK2 = 2'd3
    } state_t;

    state_t     state;
    logic       ack_q;          // INTA delayed one clock, idles high
    logic [2:0] lvl_reg;        // level captured at the first INTA
    logic       spur_reg;       // first INTA found no pending request
    logic       served_reg;     // captured level belongs to a cascaded slave

    logic       int_cpu_reg;
    logic       freeze_reg;
    logic [7:0] set_isr_reg;
    logic [7:0] clear_irr_reg;
    logic [7:0] aeoi_clear_reg;
    logic [2:0] cascade_o_reg;
    logic       cascade_oe_reg;
    logic       own_bus_reg;
    logic [7:0] data_reg;

    logic       fall;
    logic       rise;
    logic       vec_none;
    logic [2:0] vec_lowest;
    logic [2:0] new_lvl;
    logic       new_served;
    logic [7:0] new_onehot;
    logic [7:0] lvl_onehot;
    logic       drive;

    // INTA edge detection against the one-cycle-delayed copy
    assign fall = ack_q & ~bus.int_ack;
    assign rise = ~ack_q & bus.int_ack;

    // Lowest set bit of the one-hot winner; scanning downward lets the
    // lowest index overwrite any higher one should several bits be set.
    always_comb begin
        vec_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.interrupt_vector[i]) begin
                vec_lowest = i[2:0];
            end
        end
    end

    // Level that would be latched if the first INTA arrived this cycle
    always_comb begin
        vec_none   = (bus.interrupt_vector == 8'h00);
        new_lvl    = vec_none ? SPURIOUS_LEVEL : vec_lowest;
        new_served = bus.sp_en & ~bus.single_mode & bus.icw3_slave_mask[new_lvl];
        new_onehot = 8'd1 << new_lvl;
        lvl_onehot = 8'd1 << lvl_reg;
    end

    // Who owns the data bus during the second INTA. A master (or a lone
    // chip) answers unless a slave was selected; a slave answers only when
    // the master's cascade code names it and it actually had a request.
    always_comb begin
        if (bus.sp_en || bus.single_mode) begin
            drive = ~served_reg;
        end else begin
            drive = (bus.cascade_i == bus.cascade_id) & ~spur_reg;
        end
    end

    // Acknowledge FSM with all outputs registered in the same block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ack_q          <= 1'b1;
            lvl_reg        <= 3'd0;
            spur_reg       <= 1'b0;
            served_reg     <= 1'b0;
            int_cpu_reg    <= 1'b0;
            freeze_reg     <= 1'b0;
            set_isr_reg    <= 8'h00;
            clear_irr_reg  <= 8'h00;
            aeoi_clear_reg <= 8'h00;
            cascade_o_reg  <= 3'd0;
            cascade_oe_reg <= 1'b0;
            own_bus_reg    <= 1'b0;
            data_reg       <= 8'h00;
        end else begin
            ack_q <= bus.int_ack;

            // Strobes are single-cycle unless re-asserted below
            set_isr_reg    <= 8'h00;
            clear_irr_reg  <= 8'h00;
            aeoi_clear_reg <= 8'h00;

            if (bus.icw1_write) begin
                // Re-initialisation abandons any acknowledge in flight
                state          <= IDLE;
                spur_reg       <= 1'b0;
                served_reg     <= 1'b0;
                int_cpu_reg    <= 1'b0;
                freeze_reg     <= 1'b0;
                cascade_o_reg  <= 3'd0;
                cascade_oe_reg <= 1'b0;
                own_bus_reg    <= 1'b0;
                data_reg       <= 8'h00;
            end else begin
                case (state)
                    IDLE: begin
                        freeze_reg     <= 1'b0;
                        own_bus_reg    <= 1'b0;
                        data_reg       <= 8'h00;
                        cascade_o_reg  <= 3'd0;
                        cascade_oe_reg <= 1'b0;
                        if (fall) begin
                            state       <= ACK1;
                            lvl_reg     <= new_lvl;
                            spur_reg    <= vec_none;
                            served_reg  <= new_served;
                            int_cpu_reg <= 1'b0;
                            freeze_reg  <= 1'b1;
                            if (!vec_none) begin
                                set_isr_reg   <= new_onehot;
                                clear_irr_reg <= new_onehot;
                            end
                            // Master tells the selected slave who it is
                            cascade_o_reg  <= new_served ? new_lvl : 3'd0;
                            cascade_oe_reg <= new_served;
                        end else begin
                            int_cpu_reg <= (bus.interrupt_vector != 8'h00);
                        end
                    end

                    ACK1: begin
                        // First INTA carries no vector; just wait for it to end
                        if (rise) begin
                            state <= GAP;
                        end
                    end

                    GAP: begin
                        if (fall) begin
                            state       <= ACK2;
                            own_bus_reg <= drive;
                            data_reg    <= {bus.icw2_base, lvl_reg};
                        end
                    end

                    ACK2: begin
                        if (rise) begin
                            state          <= IDLE;
                            if (bus.auto_eoi && !spur_reg) begin
                                aeoi_clear_reg <= lvl_onehot;
                            end
                            freeze_reg     <= 1'b0;
                            own_bus_reg    <= 1'b0;
                            data_reg       <= 8'h00;
                            cascade_o_reg  <= 3'd0;
                            cascade_oe_reg <= 1'b0;
                            served_reg     <= 1'b0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.interrupt_to_cpu       = int_cpu_reg;
    assign bus.freeze                 = freeze_reg;
    assign bus.set_isr                = set_isr_reg;
    assign bus.clear_IRR              = clear_irr_reg;
    assign bus.aeoi_clear             = aeoi_clear_reg;
    assign bus.cascade_o              = cascade_o_reg;
    assign bus.cascade_oe             = cascade_oe_reg;
    assign bus.out_control_logic_data = own_bus_reg;
    assign bus.control_logic_data     = data_reg;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for the interrupt-acknowledge sequencer. Inputs change on the
// falling clock edge, outputs are sampled on the following falling edge.
// Expected values go into a scoreboard queue as each phase is driven and
// are popped and compared once the DUT has had its clock edge.
module tb_inta_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inta_sequencer_if bus ();

    inta_sequencer #(.SPURIOUS_LEVEL(3'd7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string tag);
        case (tag)
            "int":     return {31'd0, bus.interrupt_to_cpu};
            "freeze":  return {31'd0, bus.freeze};
            "set_isr": return {24'd0, bus.set_isr};
            "clr_irr": return {24'd0, bus.clear_IRR};
            "aeoi":    return {24'd0, bus.aeoi_clear};
            "cas_o":   return {29'd0, bus.cascade_o};
            "cas_oe":  return {31'd0, bus.cascade_oe};
            "own":     return {31'd0, bus.out_control_logic_data};
            "data":    return {24'd0, bus.control_logic_data};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain(input string phase);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq({phase, ".", e.tag}, observe(e.tag), e.val);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference: level and ownership as the 8259 defines them
    function automatic logic [2:0] ref_level(input logic [7:0] vec);
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) return i[2:0];
        end
        return 3'd7;
    endfunction

    // Full two-pulse acknowledge; vec_gap replaces the request during GAP
    task automatic run_ack(input string name, input logic [7:0] vec, input logic [7:0] vec_gap);
        logic [2:0] lvl;
        logic       spur;
        logic       served;
        logic       drv;
        logic [7:0] oh;

        lvl    = ref_level(vec);
        spur   = (vec == 8'h00);
        served = bus.sp_en && !bus.single_mode && bus.icw3_slave_mask[lvl];
        if (bus.sp_en || bus.single_mode) drv = !served;
        else                              drv = (bus.cascade_i == bus.cascade_id) && !spur;
        oh = 8'd1 << lvl;

        bus.interrupt_vector = vec;
        step();
        step();
        sb_push("int", {31'd0, vec != 8'h00});
        sb_push("freeze", 0);
        sb_drain({name, ".idle"});

        bus.int_ack = 1'b0;                       // INTA1 falls
        step();
        sb_push("set_isr", spur ? 32'd0 : {24'd0, oh});
        sb_push("clr_irr", spur ? 32'd0 : {24'd0, oh});
        sb_push("freeze", 1);
        sb_push("int", 0);
        sb_push("own", 0);
        sb_push("cas_oe", {31'd0, served});
        sb_push("cas_o", served ? {29'd0, lvl} : 32'd0);
        sb_drain({name, ".ack1"});

        step();
        sb_push("set_isr", 0);
        sb_push("clr_irr", 0);
        sb_drain({name, ".ack1b"});

        bus.int_ack = 1'b1;                       // INTA1 rises
        step();
        sb_push("own", 0);
        sb_push("freeze", 1);
        sb_push("cas_oe", {31'd0, served});
        sb_drain({name, ".gap"});

        bus.interrupt_vector = vec_gap;
        step();
        bus.int_ack = 1'b0;                       // INTA2 falls
        step();
        sb_push("own", {31'd0, drv});
        sb_push("data", {24'd0, bus.icw2_base, lvl});
        sb_push("freeze", 1);
        sb_push("cas_oe", {31'd0, served});
        sb_push("cas_o", served ? {29'd0, lvl} : 32'd0);
        sb_drain({name, ".ack2"});

        step();
        bus.int_ack = 1'b1;                       // INTA2 rises
        step();
        sb_push("aeoi", (bus.auto_eoi && !spur) ? {24'd0, oh} : 32'd0);
        sb_push("freeze", 0);
        sb_push("own", 0);
        sb_push("data", 0);
        sb_push("cas_oe", 0);
        sb_push("cas_o", 0);
        sb_drain({name, ".end"});

        step();
        sb_push("aeoi", 0);
        sb_push("int", {31'd0, vec_gap != 8'h00});
        sb_drain({name, ".after"});
        $display("[TB] %s vec=%02h lvl=%0d spur=%0d served=%0d drive=%0d done",
                 name, vec, lvl, spur, served, drv);
    endtask

    initial begin
        bus.icw1_write       = 1'b0;
        bus.int_ack          = 1'b1;
        bus.interrupt_vector = 8'h01;
        bus.icw2_base        = 5'h11;
        bus.icw3_slave_mask  = 8'h00;
        bus.cascade_id       = 3'd0;
        bus.sp_en            = 1'b1;
        bus.single_mode      = 1'b0;
        bus.auto_eoi         = 1'b0;
        bus.cascade_i        = 3'd0;

        // Reset state, with a request pending that must not raise INT yet
        step();
        step();
        sb_push("int", 0);
        sb_push("freeze", 0);
        sb_push("set_isr", 0);
        sb_push("own", 0);
        sb_push("data", 0);
        sb_push("cas_oe", 0);
        sb_drain("reset");
        $display("[TB] reset state checked");
        rst_n = 1'b1;
        bus.interrupt_vector = 8'h00;
        step();

        // Plain master acknowledge; vector byte should be 8'h8B
        run_ack("master_ir3", 8'h08, 8'h08);
        check_eq("master_ir3.byte_const", {24'd0, 8'h8B}, {27'd0, 5'd0} | 32'h0 | {24'd0, 5'h11, 3'd3});

        // Automatic EOI
        bus.auto_eoi = 1'b1;
        run_ack("aeoi_ir0", 8'h01, 8'h00);

        // Spurious: no ISR strobe, no AEOI, level 7 in the vector
        run_ack("spurious", 8'h00, 8'h00);
        bus.auto_eoi = 1'b0;

        // Master with a slave on IR2: cascade driven, no vector from master
        bus.icw3_slave_mask = 8'h04;
        run_ack("master_casc", 8'h04, 8'h00);

        // Same mask in single mode: cascade disabled, master drives vector
        bus.single_mode = 1'b1;
        run_ack("single_mode", 8'h04, 8'h00);
        bus.single_mode = 1'b0;

        // Slave addressed by the master's cascade code
        bus.sp_en      = 1'b0;
        bus.cascade_id = 3'd2;
        bus.cascade_i  = 3'd2;
        run_ack("slave_hit", 8'h04, 8'h00);
        bus.cascade_i  = 3'd3;
        run_ack("slave_miss", 8'h04, 8'h00);
        bus.sp_en      = 1'b1;

        // Request changes during GAP; latched level must survive
        bus.icw3_slave_mask = 8'h00;
        run_ack("vec_change", 8'h02, 8'h01);

        // Asynchronous reset in GAP of a cascaded acknowledge
        bus.icw3_slave_mask  = 8'h04;
        bus.interrupt_vector = 8'h04;
        step();
        bus.int_ack = 1'b0;
        step();
        step();
        bus.int_ack = 1'b1;
        step();
        sb_push("cas_oe", 1);
        sb_push("freeze", 1);
        sb_drain("rst_gap.pre");
        rst_n = 1'b0;
        step();
        sb_push("freeze", 0);
        sb_push("own", 0);
        sb_push("cas_oe", 0);
        sb_push("int", 0);
        sb_drain("rst_gap.post");
        rst_n = 1'b1;
        bus.icw3_slave_mask = 8'h00;
        step();
        $display("[TB] reset during GAP checked");
        run_ack("post_reset", 8'h20, 8'h00);

        // icw1_write during ACK2 with AEOI enabled: abort, no AEOI strobe
        bus.auto_eoi         = 1'b1;
        bus.interrupt_vector = 8'h10;
        step();
        step();
        bus.int_ack = 1'b0;
        step();
        step();
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        step();
        sb_push("own", 1);
        sb_push("data", {24'd0, 5'h11, 3'd4});
        sb_drain("icw1_ack2.pre");
        bus.icw1_write = 1'b1;
        step();
        sb_push("freeze", 0);
        sb_push("own", 0);
        sb_push("data", 0);
        sb_push("cas_oe", 0);
        sb_push("aeoi", 0);
        sb_push("int", 0);
        sb_drain("icw1_ack2.post");
        bus.icw1_write = 1'b0;
        bus.int_ack    = 1'b1;
        step();
        sb_push("aeoi", 0);
        sb_push("freeze", 0);
        sb_drain("icw1_ack2.release");
        step();
        sb_push("int", 1);
        sb_drain("icw1_ack2.reint");
        $display("[TB] icw1_write during ACK2 checked");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
